// File: rtl/host_link_pkg.sv
// host_link_pkg: shared state encoding and default sizing for the host link
// I/O block (job/device configuration loader and nonce result reporter).
package host_link_pkg;

    // Default widths and result FIFO depth.
    localparam int DEF_DEVICE_CONFIG_WIDTH = 8;
    localparam int DEF_JOB_CONFIG_WIDTH    = 360;
    localparam int DEF_RESULT_DATA_WIDTH   = 32;
    localparam int DEF_RESULT_DEPTH        = 4;

    // One-hot controller state.
    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_EXEC = 3'b010;
    localparam logic [2:0] ST_DONE = 3'b100;

endpackage

// File: rtl/host_link_if.sv
// host_link_if: the two host SPI links plus the hashing core result strobe.
// master = host / core side, slave = host_link_io.
interface host_link_if
    import host_link_pkg::*;
#(
    parameter int RESULT_DATA_WIDTH = DEF_RESULT_DATA_WIDTH
) ();

    logic                         sck0;
    logic                         sdi0;
    logic                         cs0_n;
    logic                         sck1;
    logic                         sdi1;
    logic                         sdo1;
    logic                         cs1_n;
    logic [RESULT_DATA_WIDTH-1:0] shapool_result;
    logic                         shapool_success;

    modport master (
        output sck0, sdi0, cs0_n, sck1, sdi1, cs1_n, shapool_result, shapool_success,
        input  sdo1
    );

    modport slave (
        input  sck0, sdi0, cs0_n, sck1, sdi1, cs1_n, shapool_result, shapool_success,
        output sdo1
    );

endinterface

// File: rtl/host_link_result_fifo.sv
// host_link_result_fifo: DEPTH x DATA_WIDTH result FIFO with synchronous
// reset, synchronous clear, a combinational head view and a registered
// occupancy count. A push on a full FIFO is accepted when a pop happens in
// the same cycle.
module host_link_result_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_WIDTH-1:0]        push_data,
    output logic [DATA_WIDTH-1:0]        head_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (clr) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/host_link_io.sv
// host_link_io: loads job/device configuration over two SPI links while
// idle, collects nonce results from the hashing core while executing, and
// streams them back to the host over SPI1 once halted.
// Build option: define HOST_LINK_HALT_ON_FULL_EN to halt (enter DONE) as soon
// as the result FIFO fills; otherwise execution continues and extra results
// are dropped with the sticky overflow flag set.
module host_link_io
    import host_link_pkg::*;
#(
    parameter int DEVICE_CONFIG_WIDTH = DEF_DEVICE_CONFIG_WIDTH,
    parameter int JOB_CONFIG_WIDTH    = DEF_JOB_CONFIG_WIDTH,
    parameter int RESULT_DATA_WIDTH   = DEF_RESULT_DATA_WIDTH,
    parameter int RESULT_DEPTH        = DEF_RESULT_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             run,
    host_link_if.slave                       bus,
    output logic [DEVICE_CONFIG_WIDTH-1:0]   device_config,
    output logic [JOB_CONFIG_WIDTH-1:0]      job_config,
    output logic                             ready,
    output logic [$clog2(RESULT_DEPTH):0]    result_count,
    output logic                             overflow
);

    localparam int CNT_W = $clog2(RESULT_DEPTH) + 1;
    localparam int BIT_W = $clog2(RESULT_DATA_WIDTH);

`ifdef HOST_LINK_HALT_ON_FULL_EN
    localparam logic HALT_ON_FULL = 1'b1;
`else
    localparam logic HALT_ON_FULL = 1'b0;
`endif

    // Synchronisers: bit [1] is the synchronised level, bit [2] its previous value.
    logic [2:0] sck0_sync_r;
    logic [2:0] sck1_sync_r;
    logic [2:0] cs1_sync_r;
    logic [1:0] cs0_sync_r;
    logic [1:0] sdi0_sync_r;
    logic [1:0] sdi1_sync_r;

    logic sck0_rise_s;
    logic sck1_rise_s;
    logic cs0_low_s;
    logic cs1_low_s;
    logic cs1_fall_s;
    logic cs1_rise_s;
    logic sdi0_s;
    logic sdi1_s;

    state_t state_r;
    state_t state_nxt_s;
    logic   in_idle_s;
    logic   in_exec_s;
    logic   in_done_s;

    logic [RESULT_DATA_WIDTH-1:0] out_r;
    logic [BIT_W-1:0]             bit_cnt_r;
    logic                         reload_r;

    logic                         fifo_clr_s;
    logic                         push_req_s;
    logic                         fifo_push_s;
    logic                         fifo_pop_s;
    logic                         drop_s;
    logic                         shift_out_s;
    logic                         word_done_s;
    logic [RESULT_DATA_WIDTH-1:0] fifo_head_s;
    logic [CNT_W-1:0]             fifo_count_s;
    logic                         fifo_full_s;
    logic                         fifo_empty_s;

    // Two-flop synchronisers with one extra history bit for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck0_sync_r <= 3'b000;
            sck1_sync_r <= 3'b000;
            cs1_sync_r  <= 3'b000;
            cs0_sync_r  <= 2'b00;
            sdi0_sync_r <= 2'b00;
            sdi1_sync_r <= 2'b00;
        end else begin
            sck0_sync_r <= {sck0_sync_r[1:0], bus.sck0};
            sck1_sync_r <= {sck1_sync_r[1:0], bus.sck1};
            cs1_sync_r  <= {cs1_sync_r[1:0], bus.cs1_n};
            cs0_sync_r  <= {cs0_sync_r[0], bus.cs0_n};
            sdi0_sync_r <= {sdi0_sync_r[0], bus.sdi0};
            sdi1_sync_r <= {sdi1_sync_r[0], bus.sdi1};
        end
    end

    assign sck0_rise_s = (sck0_sync_r[2:1] == 2'b01);
    assign sck1_rise_s = (sck1_sync_r[2:1] == 2'b01);
    assign cs1_fall_s  = (cs1_sync_r[2:1] == 2'b10);
    assign cs1_rise_s  = (cs1_sync_r[2:1] == 2'b01);
    assign cs0_low_s   = !cs0_sync_r[1];
    assign cs1_low_s   = !cs1_sync_r[1];
    assign sdi0_s      = sdi0_sync_r[1];
    assign sdi1_s      = sdi1_sync_r[1];

    assign in_idle_s = (state_r == ST_IDLE);
    assign in_exec_s = (state_r == ST_EXEC);
    assign in_done_s = (state_r == ST_DONE);

    assign fifo_clr_s  = in_idle_s && run;
    assign push_req_s  = in_exec_s && bus.shapool_success;
    assign fifo_push_s = push_req_s && !fifo_full_s;
    assign drop_s      = push_req_s && fifo_full_s;
    assign shift_out_s = in_done_s && sck1_rise_s && cs1_low_s;
    assign word_done_s = shift_out_s && (bit_cnt_r == BIT_W'(RESULT_DATA_WIDTH - 1));
    assign fifo_pop_s  = word_done_s;

    // Next-state selection; a host select in EXEC wins over run dropping.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) state_nxt_s = ST_EXEC;
                else     state_nxt_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (cs1_low_s)                       state_nxt_s = ST_DONE;
                else if (!run)                       state_nxt_s = ST_IDLE;
                else if (HALT_ON_FULL && fifo_full_s) state_nxt_s = ST_DONE;
                else                                 state_nxt_s = ST_EXEC;
            end
            ST_DONE: begin
                if (!run) state_nxt_s = ST_IDLE;
                else      state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Controller state, registered ready and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            ready    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready   <= (state_nxt_s == ST_DONE);
            if (fifo_clr_s) begin
                overflow <= 1'b0;
            end else if (drop_s) begin
                overflow <= 1'b1;
            end
        end
    end

    // Configuration shift registers, MSB first, only while idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            job_config    <= {JOB_CONFIG_WIDTH{1'b0}};
            device_config <= {DEVICE_CONFIG_WIDTH{1'b0}};
        end else if (in_idle_s) begin
            if (sck0_rise_s && cs0_low_s) begin
                job_config <= {job_config[JOB_CONFIG_WIDTH-2:0], sdi0_s};
            end
            if (sck1_rise_s && cs1_low_s) begin
                device_config <= {device_config[DEVICE_CONFIG_WIDTH-2:0], sdi1_s};
            end
        end
    end

    // Result readout: reload one cycle after entering DONE or finishing a
    // word (so the head reflects the latest push/pop), or on a select fall;
    // a select rise abandons a partial word without popping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_r     <= {RESULT_DATA_WIDTH{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            reload_r  <= 1'b0;
        end else begin
            reload_r <= (in_exec_s && (state_nxt_s == ST_DONE)) || word_done_s;
            if (!in_done_s) begin
                bit_cnt_r <= {BIT_W{1'b0}};
            end else if (reload_r || cs1_fall_s) begin
                out_r     <= fifo_empty_s ? {RESULT_DATA_WIDTH{1'b0}} : fifo_head_s;
                bit_cnt_r <= {BIT_W{1'b0}};
            end else if (cs1_rise_s) begin
                bit_cnt_r <= {BIT_W{1'b0}};
            end else if (shift_out_s) begin
                out_r     <= {out_r[RESULT_DATA_WIDTH-2:0], sdi1_s};
                bit_cnt_r <= word_done_s ? {BIT_W{1'b0}} : (bit_cnt_r + BIT_W'(1'b1));
            end
        end
    end

    assign bus.sdo1     = in_done_s ? out_r[RESULT_DATA_WIDTH-1]
                                    : device_config[DEVICE_CONFIG_WIDTH-1];
    assign result_count = fifo_count_s;

    host_link_result_fifo #(
        .DATA_WIDTH (RESULT_DATA_WIDTH),
        .DEPTH      (RESULT_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (fifo_clr_s),
        .push      (fifo_push_s),
        .pop       (fifo_pop_s),
        .push_data (bus.shapool_result),
        .head_data (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_host_link_io.sv
// tb_host_link_io: directed scenario sequence with randomized data for
// host_link_io; expected results come from a queue-based result model and
// whole-word configuration values. Honours HOST_LINK_HALT_ON_FULL_EN.
module tb_host_link_io;
    import host_link_pkg::*;

    localparam int DW = 8;
    localparam int JW = 360;
    localparam int RW = 32;
    localparam int RD = 4;
    localparam int CW = $clog2(RD) + 1;

    typedef logic [511:0] wide_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          run;
    logic [DW-1:0] device_config;
    logic [JW-1:0] job_config;
    logic          ready;
    logic [CW-1:0] result_count;
    logic          overflow;

    int n_vec = 0;
    int n_mis = 0;

    logic [RW-1:0] exp_q[$];
    logic          exp_ovf;

    host_link_if #(.RESULT_DATA_WIDTH(RW)) bus ();

    host_link_io #(
        .DEVICE_CONFIG_WIDTH (DW),
        .JOB_CONFIG_WIDTH    (JW),
        .RESULT_DATA_WIDTH   (RW),
        .RESULT_DEPTH        (RD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run           (run),
        .bus           (bus),
        .device_config (device_config),
        .job_config    (job_config),
        .ready         (ready),
        .result_count  (result_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input wide_t obs, input wide_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi0_bit(input logic din);
        bus.sdi0 = din;
        wait_clk(4);
        bus.sck0 = 1'b1;
        wait_clk(4);
        bus.sck0 = 1'b0;
    endtask

    // Host samples sdo1 just before raising sck1.
    task automatic spi1_bit(input logic din, output logic dout);
        bus.sdi1 = din;
        wait_clk(4);
        dout = bus.sdo1;
        bus.sck1 = 1'b1;
        wait_clk(4);
        bus.sck1 = 1'b0;
    endtask

    task automatic read_bits(input int nbits, output logic [RW-1:0] w);
        logic d;
        w = {RW{1'b0}};
        for (int i = 0; i < nbits; i++) begin
            spi1_bit(1'($urandom_range(1, 0)), d);
            w = {w[RW-2:0], d};
        end
    endtask

    task automatic strobe(input logic [RW-1:0] v);
        bus.shapool_result  = v;
        bus.shapool_success = 1'b1;
        wait_clk(1);
        bus.shapool_success = 1'b0;
    endtask

    task automatic model_push(input logic [RW-1:0] v);
        if (exp_q.size() < RD) exp_q.push_back(v);
        else                   exp_ovf = 1'b1;
    endtask

    task automatic expect_word(input string tag, input logic [RW-1:0] got);
        logic [RW-1:0] e;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else                   e = {RW{1'b0}};
        check(tag, wide_t'(got), wide_t'(e));
    endtask

    initial begin
        logic [JW-1:0] exp_job;
        logic [DW-1:0] b1;
        logic [DW-1:0] b2;
        logic [15:0]   chain_in;
        logic [15:0]   chain_out;
        logic          d;
        logic [RW-1:0] got;
        logic [RW-1:0] va;
        logic [RW-1:0] vb;

        reset_n = 1'b0; run = 1'b0;
        bus.sck0 = 1'b0; bus.sdi0 = 1'b0; bus.cs0_n = 1'b1;
        bus.sck1 = 1'b0; bus.sdi1 = 1'b0; bus.cs1_n = 1'b1;
        bus.shapool_result = {RW{1'b0}}; bus.shapool_success = 1'b0;
        exp_ovf = 1'b0;
        wait_clk(3);
        check("rst_ready", wide_t'(ready), wide_t'(1'b0));
        check("rst_overflow", wide_t'(overflow), wide_t'(1'b0));
        check("rst_count", wide_t'(result_count), wide_t'(0));
        check("rst_job", wide_t'(job_config), wide_t'(0));
        check("rst_dev", wide_t'(device_config), wide_t'(0));
        check("rst_sdo1", wide_t'(bus.sdo1), wide_t'(1'b0));
        reset_n = 1'b1;
        wait_clk(4);

        // Job load: 360 bits of 0xA5 repeated, MSB first.
        exp_job = {(JW / 8){8'hA5}};
        bus.cs0_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < JW; i++) spi0_bit(exp_job[JW-1-i]);
        wait_clk(4);
        bus.cs0_n = 1'b1;
        wait_clk(4);
        check("job_load", wide_t'(job_config), wide_t'(exp_job));
        check("job_load_dev_kept", wide_t'(device_config), wide_t'(0));

        // Device config daisy chain: second byte stays, first byte comes out on sdo1.
        b1 = 8'($urandom());
        b2 = 8'($urandom());
        chain_in = {b1, b2};
        bus.cs1_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 16; i++) begin
            spi1_bit(chain_in[15-i], d);
            chain_out[15-i] = d;
        end
        wait_clk(4);
        bus.cs1_n = 1'b1;
        wait_clk(4);
        check("dev_load", wide_t'(device_config), wide_t'(b2));
        check("dev_chain_out", wide_t'(chain_out), wide_t'({8'h00, b1}));
        check("idle_sdo1", wide_t'(bus.sdo1), wide_t'(b2[DW-1]));

        // Enter EXEC; job SPI traffic must not disturb the job config.
        run = 1'b1;
        wait_clk(3);
        check("exec_ready", wide_t'(ready), wide_t'(1'b0));
        bus.cs0_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 4; i++) spi0_bit(1'($urandom_range(1, 0)));
        bus.cs0_n = 1'b1;
        wait_clk(4);
        check("exec_job_frozen", wide_t'(job_config), wide_t'(exp_job));

        // Single result.
        bus.shapool_result  = 32'h12345678;
        bus.shapool_success = 1'b1;
        check("single_count_before", wide_t'(result_count), wide_t'(0));
        wait_clk(1);
        bus.shapool_success = 1'b0;
        check("single_count_after", wide_t'(result_count), wide_t'(1));
        bus.cs1_n = 1'b0;
        wait_clk(6);
        check("single_ready", wide_t'(ready), wide_t'(1'b1));
        read_bits(RW, got);
        check("single_word", wide_t'(got), wide_t'(32'h12345678));
        wait_clk(4);
        check("single_count_popped", wide_t'(result_count), wide_t'(0));
        bus.cs1_n = 1'b1;
        wait_clk(4);
        run = 1'b0;
        wait_clk(1);
        check("done_to_idle_ready", wide_t'(ready), wide_t'(1'b0));
        wait_clk(3);

        // Overflow / halt on full: five back-to-back results into a depth-4 FIFO.
        run = 1'b1;
        wait_clk(3);
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < RD; i++) begin
            va = $urandom();
            strobe(va);
            model_push(va);
        end
        check("fill_count", wide_t'(result_count), wide_t'(exp_q.size()));
        check("fill_ready", wide_t'(ready), wide_t'(1'b0));
        va = $urandom();
        strobe(va);
        model_push(va);
        check("full_count", wide_t'(result_count), wide_t'(exp_q.size()));
`ifdef HOST_LINK_HALT_ON_FULL_EN
        check("halt_ready", wide_t'(ready), wide_t'(1'b1));
`else
        check("full_overflow", wide_t'(overflow), wide_t'(exp_ovf));
        check("full_keep_exec", wide_t'(ready), wide_t'(1'b0));
`endif
        bus.cs1_n = 1'b0;
        wait_clk(6);
        check("full_done_ready", wide_t'(ready), wide_t'(1'b1));
        for (int k = 0; k < RD + 1; k++) begin
            read_bits(RW, got);
            expect_word($sformatf("full_read%0d", k), got);
        end
        wait_clk(4);
        check("full_drained", wide_t'(result_count), wide_t'(0));
        bus.cs1_n = 1'b1;
        wait_clk(4);
        run = 1'b0;
        wait_clk(3);
`ifndef HOST_LINK_HALT_ON_FULL_EN
        check("overflow_sticky", wide_t'(overflow), wide_t'(1'b1));
`endif

        // EXEC -> IDLE keeps FIFO contents; IDLE -> EXEC clears them.
        run = 1'b1;
        wait_clk(2);
        check("restart_overflow_clr", wide_t'(overflow), wide_t'(1'b0));
        strobe($urandom());
        strobe($urandom());
        run = 1'b0;
        wait_clk(2);
        check("retain_count", wide_t'(result_count), wide_t'(2));
        check("retain_ready", wide_t'(ready), wide_t'(1'b0));
        run = 1'b1;
        wait_clk(2);
        check("restart_count_clr", wide_t'(result_count), wide_t'(0));

        // Partial read: abandoned word is re-sent, one pop only.
        exp_q.delete();
        va = $urandom();
        vb = $urandom();
        strobe(va);
        model_push(va);
        wait_clk($urandom_range(3, 0));
        strobe(vb);
        model_push(vb);
        bus.cs1_n = 1'b0;
        wait_clk(6);
        read_bits(10, got);
        check("partial_bits", wide_t'(got[9:0]), wide_t'(va[RW-1:RW-10]));
        bus.cs1_n = 1'b1;
        wait_clk(6);
        check("partial_no_pop", wide_t'(result_count), wide_t'(2));
        bus.cs1_n = 1'b0;
        wait_clk(6);
        read_bits(RW, got);
        expect_word("partial_resend", got);
        wait_clk(4);
        check("partial_one_pop", wide_t'(result_count), wide_t'(1));
        read_bits(RW, got);
        expect_word("partial_second", got);
        wait_clk(4);
        check("partial_empty", wide_t'(result_count), wide_t'(0));
        bus.cs1_n = 1'b1;
        wait_clk(4);

        // Reset in the middle of a DONE readout.
        run = 1'b0;
        wait_clk(3);
        run = 1'b1;
        wait_clk(3);
        va = $urandom();
        strobe(va);
        bus.cs1_n = 1'b0;
        wait_clk(6);
        read_bits(5, got);
        check("pre_reset_bits", wide_t'(got[4:0]), wide_t'(va[RW-1:RW-5]));
        reset_n = 1'b0;
        run = 1'b0;
        bus.cs1_n = 1'b1;
        wait_clk(1);
        check("mid_rst_ready", wide_t'(ready), wide_t'(1'b0));
        check("mid_rst_overflow", wide_t'(overflow), wide_t'(1'b0));
        check("mid_rst_count", wide_t'(result_count), wide_t'(0));
        check("mid_rst_job", wide_t'(job_config), wide_t'(0));
        check("mid_rst_dev", wide_t'(device_config), wide_t'(0));
        check("mid_rst_sdo1", wide_t'(bus.sdo1), wide_t'(1'b0));
        reset_n = 1'b1;
        wait_clk(4);
        b1 = 8'($urandom()) | 8'h80;
        bus.cs1_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < DW; i++) spi1_bit(b1[DW-1-i], d);
        wait_clk(4);
        bus.cs1_n = 1'b1;
        wait_clk(4);
        check("post_rst_dev", wide_t'(device_config), wide_t'(b1));
        check("post_rst_sdo1", wide_t'(bus.sdo1), wide_t'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/host_link_io.md
HOST_LINK_IO -- requirements
Module: host_link_io

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk is the single clock; reset_n is synchronous and active-low.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- DEVICE_CONFIG_WIDTH, 8: device config bits (nonce_start).
- JOB_CONFIG_WIDTH, 360: job config bits (sha_state, message_head, difficulty).
- RESULT_DATA_WIDTH, 32: nonce result bits.
- RESULT_DEPTH, 4: result FIFO entries, power of two, at least 2.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: core clock.
- reset_n, in, 1: synchronous active-low reset.
- run, in, 1: host start/stop level.
- sck0, in, 1: job SPI clock.
- sdi0, in, 1: job SPI data.
- cs0_n, in, 1: job SPI select.
- sck1, in, 1: device/result SPI clock.
- sdi1, in, 1: device/result SPI data in.
- sdo1, out, 1: device/result SPI data out (daisy chain).
- cs1_n, in, 1: device/result SPI select.
- shapool_result, in, RESULT_DATA_WIDTH: candidate nonce.
- shapool_success, in, 1: candidate valid strobe.
- device_config, out, DEVICE_CONFIG_WIDTH: stored device config.
- job_config, out, JOB_CONFIG_WIDTH: stored job config.
- ready, out, 1: core halt / host notify.
- result_count, out, clog2(RESULT_DEPTH)+1: FIFO occupancy.
- overflow, out, 1: sticky flag, a result was dropped.

Function
REQ-004 sck0, sck1, sdi0, sdi1, cs0_n and cs1_n SHALL pass through two-flop synchronisers; an SCK rising edge SHALL be detected from synchronised bits [2:1].
REQ-005 The state machine SHALL have states IDLE, EXEC and DONE, one-hot encoded.
REQ-006 In IDLE, ready SHALL be 0, and on each sync rising edge of an SCK with its select low, job_config and device_config SHALL shift left, taking sdi into bit 0 (MSB first).
REQ-007 On run=1, IDLE SHALL go to EXEC on the next cycle, and the FIFO and overflow SHALL be cleared on that transition.
REQ-008 In EXEC, a shapool_success strobe SHALL push shapool_result; result_count SHALL update one cycle after the strobe.
REQ-009 In EXEC, a push when the FIFO is full SHALL drop the result and set overflow.
REQ-010 In EXEC, sync cs1_n low SHALL cause a transition to DONE with ready=1; a success strobe in that same cycle SHALL still be pushed.
REQ-011 In EXEC, run=0 (with cs1_n high) SHALL cause a transition to IDLE with the FIFO contents retained.
REQ-012 In DONE, ready SHALL be 1, and the head entry SHALL be copied into an output shift register on the sync cs1_n falling edge and after each completed word.
REQ-013 In DONE, each sync sck1 rising edge with cs1_n low SHALL shift the output register left, taking sdi1 in; after RESULT_DATA_WIDTH edges, the head SHALL be popped.
REQ-014 In DONE, an empty FIFO SHALL load all-zeros into the output register.
REQ-015 On a cs1_n rise mid-word, the bit counter SHALL clear and no pop SHALL occur, so the same entry is re-sent.
REQ-016 sdo1 SHALL be the output register MSB in DONE, and device_config MSB otherwise.
REQ-017 In DONE, run=0 SHALL cause a transition to IDLE, and ready SHALL go to 0 the next cycle.
REQ-018 The job_config and device_config registers SHALL shift only in IDLE.

Reset
REQ-019 With reset_n low at a clk edge: state=IDLE, ready=0, overflow=0, FIFO empty, result_count=0, job_config=0, device_config=0, bit counter=0, all synchronisers=0.
REQ-020 Reset SHALL take priority over every other event, including reset mid-shift and reset while in DONE.

Configuration
REQ-021 The macro HOST_LINK_HALT_ON_FULL_EN SHALL select the full-FIFO behaviour.
REQ-022 With HOST_LINK_HALT_ON_FULL_EN defined, the FIFO becoming full in EXEC SHALL transition to DONE with ready=1 on the following cycle.
REQ-023 With HOST_LINK_HALT_ON_FULL_EN undefined, EXEC SHALL continue when the FIFO is full and further results SHALL be dropped per REQ-009.

Structure
REQ-024 Package host_link_pkg SHALL hold the state type and constants, and the default widths and depth.
REQ-025 Sub-module host_link_result_fifo SHALL hold the RESULT_DEPTH x RESULT_DATA_WIDTH FIFO, with synchronous reset, push/pop and count, and with simultaneous push and pop on a full FIFO allowed.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Job load: reset_n low then high, shift 360 bits of pattern 0xA5.. via SPI0 -> job_config matches bit-exact, device_config unchanged.
- Single result: run=1, success with 0x12345678, assert cs1_n, clock 32 bits -> sdo1 stream is 0x12345678, result_count goes 1->0, ready=1.
- Overflow, macro undefined: 5 successes with depth 4 -> result_count=4, overflow=1, readout gives the first four values in order.
- Halt on full, macro defined: 4th success -> DONE and ready=1 one cycle later; a 5th strobe is not pushed.
- Partial read: 10 sck1 edges, cs1_n high, then a full 32-bit read -> the same entry is re-sent in full, and only one pop occurs.
- Reset mid-DONE: reset_n low during a readout -> all outputs per REQ-019 next edge; sdo1 follows device_config MSB.
